// File: rtl/sw_debounce.sv
// sw_debounce: conditions the raw board slide switches into clean levels.
// Each bit is double-flop synchronised, then must hold a new level for
// DEBOUNCE_CYCLES consecutive clocks before the clean output follows it.
// A one-cycle rise/fall strobe marks the first cycle of each new clean level.
module sw_debounce #(
   parameter int WIDTH           = 18,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic             CLOCK_50,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             changed
);

   // Last count value before a level qualifies; the counter never goes past it.
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [CNT_W-1:0] r_cnt [WIDTH];
   logic [WIDTH-1:0] r_clean;
   logic [WIDTH-1:0] r_rise;
   logic [WIDTH-1:0] r_fall;
   logic [WIDTH-1:0] w_strobe;

   // Synchroniser, per-bit stability counters, clean level and strobes.
   // Reset is asynchronous so a partial count is discarded immediately.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_clean <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= sw_in;
         r_sync2 <= r_sync1;
         for (int i = 0; i < WIDTH; i++) begin
            // Strobes last one cycle unless a new qualification fires below.
            r_rise[i] <= 1'b0;
            r_fall[i] <= 1'b0;
            if (r_sync2[i] == r_clean[i]) begin
               // Any return to the clean level restarts qualification.
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == LP_LAST) begin
               r_clean[i] <= r_sync2[i];
               r_cnt[i]   <= '0;
               r_rise[i]  <= r_sync2[i];
               r_fall[i]  <= ~r_sync2[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Outputs come straight from registers; changed is a plain OR-reduce.
   assign w_strobe = r_rise | r_fall;
   assign sw_clean = r_clean;
   assign sw_rise  = r_rise;
   assign sw_fall  = r_fall;
   assign changed  = |w_strobe;

endmodule
